chirp_cfg_sequencer: RTL
========================

// Module: chirp_cfg_sequencer
// PURPOSE
// Run-time configuration sequencer for the cyclic chirp generator. The chirp accepts
// depth/deriv/offset only once after enable rises, so this block shadows register
// writes, forces a disable/re-enable cycle on every update, presents the new words
// on the chirp din handshake, then counts G_SETTLE output samples before flagging the
// chirp output as settled. Sits between the register bank and the chirp instance.
// PARAMETERS
// G_DWIDTH       24  width of depth/deriv/offset words
// G_OFF_CYCLES   4   cycles chirp_enable is held low per reload (>=1)
// G_SETTLE       16  accepted chirp output samples before settled=1 (>=1)
// PORTS
// clk               in   1         clock
// reset_n           in   1         asynchronous reset, active low
// cfg_run           in   1         1 = chirp requested on, 0 = chirp off
// cfg_depth         in   G_DWIDTH  chirp depth (unsigned)
// cfg_deriv         in   G_DWIDTH  freq derivative (signed)
// cfg_offset        in   G_DWIDTH  freq offset (signed)
// cfg_update        in   1         1-cycle pulse: capture cfg_* and reload
// cfg_busy          out  1         1 in S_OFF/S_LOAD/S_SETTLE
// chirp_enable      out  1         to chirp enable
// chirp_depth       out  G_DWIDTH  to chirp_depth_din (shadow reg)
// chirp_deriv       out  G_DWIDTH  to freq_deriv_din (shadow reg)
// chirp_offset      out  G_DWIDTH  to freq_offset_din (shadow reg)
// chirp_din_valid   out  1         to chirp din_valid
// chirp_din_ready   in   1         from chirp din_ready
// chirp_dout_valid  in   1         monitor: chirp dout_valid
// chirp_dout_ready  in   1         monitor: downstream dout_ready
// settled           out  1         1 = chirp output valid for use
// BEHAVIOUR
// - Reset (async, reset_n=0): state S_IDLE; all outputs 0; shadow regs 0; counters 0.
// - All outputs registered. Shadow regs load from cfg_* on cfg_update (any state, incl. S_IDLE).
// - S_IDLE: chirp_enable=0. cfg_run=1 -> S_OFF (off_cnt=0).
// - S_OFF: chirp_enable=0, din_valid=0; off_cnt++; at off_cnt==G_OFF_CYCLES-1 -> S_LOAD.
// - S_LOAD: chirp_enable=1, chirp_din_valid=1 held until chirp_din_valid&chirp_din_ready;
//   that cycle -> S_SETTLE, din_valid drops next cycle, set_cnt=0. Shadow regs stable
//   while din_valid=1 except via cfg_update (which also leaves S_LOAD, see below).
// - S_SETTLE: chirp_enable=1; set_cnt++ on each chirp_dout_valid&chirp_dout_ready;
//   at G_SETTLE-th handshake -> S_RUN.
// - S_RUN: chirp_enable=1, settled=1.
// - cfg_update while cfg_run=1 (any non-IDLE state, or IDLE with cfg_run=1): next state
//   S_OFF, off_cnt=0, settled=0, din_valid=0; latest values win (update in S_OFF restarts count).
// - cfg_update coincident with LOAD handshake: update wins -> S_OFF (chirp is disabled anyway).
// - cfg_run=0 in any state: next state S_IDLE; chirp_enable, din_valid, settled -> 0.
//   cfg_run=0 has priority over cfg_update (shadow regs still capture).
// - cfg_run rising in S_IDLE always goes through S_OFF (guaranteed chirp re-init).
// - cfg_busy = (state in {S_OFF,S_LOAD,S_SETTLE}); settled=1 only in S_RUN.
// - Latency: cfg_update at cycle t -> chirp_enable=0 from t+1, =1 at t+1+G_OFF_CYCLES.
// - Counters sized $clog2(max(G_OFF_CYCLES,G_SETTLE))+1; no wrap beyond terminal value.
// TESTING
// - reset_n=0 mid-S_SETTLE -> all outputs 0 asynchronously; after release stays S_IDLE while cfg_run=0.
// - cfg_run=1, deriv=0x000100, depth=0x400000, ready tied 1 -> enable low 4 cycles, din_valid 1 cycle, settled after 16 handshakes.
// - din_ready held 0 for 10 cycles in S_LOAD -> din_valid stays 1, shadow values unchanged, no state change.
// - cfg_update (offset=0x010000) during S_RUN -> settled=0 next cycle, enable low 4 cycles, new offset on handshake.
// - cfg_update on same cycle as LOAD handshake -> S_OFF entered, second load carries new values.
// - cfg_run=0 with concurrent cfg_update in S_SETTLE -> S_IDLE, enable=0; shadow holds new value.

Source files
------------

// File: rtl/chirp_cfg_sequencer_if.sv
// Chirp-side bundle: config words, din handshake and the dout monitor taps.
// The sequencer drives through master; the chirp core and its sink sit on slave.
interface chirp_cfg_sequencer_if #(
   parameter int G_DWIDTH = 24
);
   logic                chirp_enable;
   logic [G_DWIDTH-1:0] chirp_depth;
   logic [G_DWIDTH-1:0] chirp_deriv;
   logic [G_DWIDTH-1:0] chirp_offset;
   logic                chirp_din_valid;
   logic                chirp_din_ready;
   logic                chirp_dout_valid;
   logic                chirp_dout_ready;

   modport master (
      output chirp_enable, chirp_depth, chirp_deriv, chirp_offset,
      output chirp_din_valid,
      input  chirp_din_ready, chirp_dout_valid, chirp_dout_ready
   );

   modport slave (
      input  chirp_enable, chirp_depth, chirp_deriv, chirp_offset,
      input  chirp_din_valid,
      output chirp_din_ready, chirp_dout_valid, chirp_dout_ready
   );
endinterface

// File: rtl/chirp_cfg_sequencer.sv
// Shadows chirp config writes and replays them through a forced off/load cycle,
// then counts output samples before flagging the chirp output as settled.
module chirp_cfg_sequencer #(
   parameter int G_DWIDTH     = 24,
   parameter int G_OFF_CYCLES = 4,
   parameter int G_SETTLE     = 16
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cfg_run,
   input  logic [G_DWIDTH-1:0] cfg_depth,
   input  logic [G_DWIDTH-1:0] cfg_deriv,
   input  logic [G_DWIDTH-1:0] cfg_offset,
   input  logic                cfg_update,
   output logic                cfg_busy,
   output logic                settled,
   chirp_cfg_sequencer_if.master chirp
);
   localparam int CMAX = (G_OFF_CYCLES > G_SETTLE) ? G_OFF_CYCLES : G_SETTLE;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam logic [CW-1:0] OFF_LAST = CW'(G_OFF_CYCLES - 1);
   localparam logic [CW-1:0] SET_LAST = CW'(G_SETTLE - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_OFF, S_LOAD, S_SETTLE, S_RUN
   } state_t;

   state_t              state_q, state_d;
   logic [CW-1:0]       off_cnt_q, off_cnt_d;
   logic [CW-1:0]       set_cnt_q, set_cnt_d;
   logic [G_DWIDTH-1:0] depth_q, depth_d;
   logic [G_DWIDTH-1:0] deriv_q, deriv_d;
   logic [G_DWIDTH-1:0] offset_q, offset_d;
   logic                en_q, en_d;
   logic                dv_q, dv_d;
   logic                settled_q, settled_d;
   logic                busy_q, busy_d;

   always_comb begin
      state_d   = state_q;
      off_cnt_d = off_cnt_q;
      set_cnt_d = set_cnt_q;
      depth_d   = depth_q;
      deriv_d   = deriv_q;
      offset_d  = offset_q;
      en_d      = en_q;
      dv_d      = dv_q;
      settled_d = settled_q;
      if (cfg_update) begin
         depth_d  = cfg_depth;
         deriv_d  = cfg_deriv;
         offset_d = cfg_offset;
      end
      // Turning the chirp off outranks a reload; a reload outranks any progress.
      if (!cfg_run) begin
         state_d   = S_IDLE;
         en_d      = 1'b0;
         dv_d      = 1'b0;
         settled_d = 1'b0;
         off_cnt_d = '0;
         set_cnt_d = '0;
      end else if (cfg_update || state_q == S_IDLE) begin
         state_d   = S_OFF;
         off_cnt_d = '0;
         en_d      = 1'b0;
         dv_d      = 1'b0;
         settled_d = 1'b0;
      end else begin
         unique case (state_q)
            S_OFF: begin
               if (off_cnt_q == OFF_LAST) begin
                  state_d = S_LOAD;
                  en_d    = 1'b1;
                  dv_d    = 1'b1;
               end else begin
                  off_cnt_d = off_cnt_q + 1'b1;
               end
            end
            S_LOAD: begin
               if (dv_q && chirp.chirp_din_ready) begin
                  state_d   = S_SETTLE;
                  dv_d      = 1'b0;
                  set_cnt_d = '0;
               end
            end
            S_SETTLE: begin
               if (chirp.chirp_dout_valid && chirp.chirp_dout_ready) begin
                  if (set_cnt_q == SET_LAST) begin
                     state_d   = S_RUN;
                     settled_d = 1'b1;
                  end else begin
                     set_cnt_d = set_cnt_q + 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      busy_d = (state_d == S_OFF) || (state_d == S_LOAD) ||
               (state_d == S_SETTLE);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         off_cnt_q <= '0;
         set_cnt_q <= '0;
         depth_q   <= '0;
         deriv_q   <= '0;
         offset_q  <= '0;
         en_q      <= 1'b0;
         dv_q      <= 1'b0;
         settled_q <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         off_cnt_q <= off_cnt_d;
         set_cnt_q <= set_cnt_d;
         depth_q   <= depth_d;
         deriv_q   <= deriv_d;
         offset_q  <= offset_d;
         en_q      <= en_d;
         dv_q      <= dv_d;
         settled_q <= settled_d;
         busy_q    <= busy_d;
      end
   end

   assign chirp.chirp_enable    = en_q;
   assign chirp.chirp_depth     = depth_q;
   assign chirp.chirp_deriv     = deriv_q;
   assign chirp.chirp_offset    = offset_q;
   assign chirp.chirp_din_valid = dv_q;
   assign cfg_busy              = busy_q;
   assign settled               = settled_q;
endmodule
